// File: rtl/multicycle_control_unit.sv
// Multicycle FSM control unit for an RV32I-subset datapath: fetch, decode, execute, memory, writeback.
// Optional performance counters (cycle_cnt, retired_cnt) are enabled by defining CTRL_PERF_CNT_EN.
module multicycle_control_unit #(
  parameter int unsigned OPC_W           = 4,
  parameter int unsigned CNT_W           = 32,
  parameter int unsigned HALT_ON_ILLEGAL = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      instr,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             ir_write,
  output logic             pc_write,
  output logic             ALUsrc,
  output logic             RegWrite,
  output logic             MemRW,
  output logic             MemtoReg,
  output logic             PCsrc,
  output logic [OPC_W-1:0] opcode,
  output logic             illegal
`ifdef CTRL_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] retired_cnt
`endif
);

  typedef enum logic [2:0] {
    StIdle, StFetch, StDecode, StExecute, StMemory, StWriteback, StHalt
  } state_e;

  typedef enum logic [2:0] {ClsR, ClsI, ClsLw, ClsSw, ClsBr, ClsIll} cls_e;

  state_e           state_q, state_d;
  cls_e             cls_q, cls_dec;
  logic [31:0]      ir_q;
  logic [OPC_W-1:0] alu_q, alu_dec;
  logic             alusrc_q, alusrc_dec;
  logic             illegal_q;

  logic unused_ir;
  assign unused_ir = ^{ir_q[31], ir_q[29:15], ir_q[11:7]};

  // Instruction classification and ALU code, taken from the latched IR.
  always_comb begin
    cls_dec = ClsIll;
    unique case (ir_q[6:0])
      7'b0110011: cls_dec = ClsR;
      7'b0010011: cls_dec = ClsI;
      7'b0000011: cls_dec = ClsLw;
      7'b0100011: cls_dec = ClsSw;
      7'b1100011: cls_dec = (ir_q[14:13] == 2'b00) ? ClsBr : ClsIll;
      default:    cls_dec = ClsIll;
    endcase

    unique case (ir_q[14:12])
      3'b000:  alu_dec = OPC_W'(4'b0001);
      3'b001:  alu_dec = OPC_W'(4'b0110);
      3'b010:  alu_dec = OPC_W'(4'b0101);
      3'b011:  alu_dec = OPC_W'(4'b0101);
      3'b100:  alu_dec = OPC_W'(4'b0100);
      3'b101:  alu_dec = OPC_W'(4'b0111);
      3'b110:  alu_dec = OPC_W'(4'b0011);
      default: alu_dec = OPC_W'(4'b0000);
    endcase
    if (cls_dec == ClsLw || cls_dec == ClsSw) begin
      alu_dec = OPC_W'(4'b0001);
    end else if (cls_dec == ClsBr) begin
      alu_dec = OPC_W'(4'b0010);
    end else if (cls_dec == ClsR && ir_q[14:12] == 3'b000 && ir_q[30]) begin
      alu_dec = OPC_W'(4'b0010);
    end
    alusrc_dec = (cls_dec == ClsI) || (cls_dec == ClsLw) || (cls_dec == ClsSw);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      ir_q      <= '0;
      cls_q     <= ClsR;
      alu_q     <= '0;
      alusrc_q  <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (ir_write) begin
        ir_q <= instr;
      end
      if (state_q == StDecode) begin
        cls_q    <= cls_dec;
        alu_q    <= alu_dec;
        alusrc_q <= alusrc_dec;
        if (cls_dec == ClsIll) begin
          illegal_q <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    ir_write = 1'b0;
    pc_write = 1'b0;
    ALUsrc   = 1'b0;
    RegWrite = 1'b0;
    MemRW    = 1'b0;
    MemtoReg = 1'b0;
    PCsrc    = 1'b0;
    opcode   = '0;
    illegal  = illegal_q;

    unique case (state_q)
      StIdle: state_d = StFetch;
      StFetch: begin
        if (mem_ready) begin
          ir_write = 1'b1;
          state_d  = StDecode;
        end
      end
      StDecode: begin
        if (cls_dec != ClsIll) begin
          state_d = StExecute;
        end else if (HALT_ON_ILLEGAL != 0) begin
          state_d = StHalt;
        end else begin
          // Illegal word retires as a NOP: advance PC, no other writes.
          pc_write = 1'b1;
          state_d  = StFetch;
        end
      end
      StExecute: begin
        opcode = alu_q;
        ALUsrc = alusrc_q;
        unique case (cls_q)
          ClsBr: begin
            PCsrc    = ir_q[12] ? ~zero : zero;
            pc_write = 1'b1;
            state_d  = StFetch;
          end
          ClsLw, ClsSw: state_d = StMemory;
          default:      state_d = StWriteback;
        endcase
      end
      StMemory: begin
        opcode = alu_q;
        ALUsrc = alusrc_q;
        MemRW  = (cls_q == ClsSw);
        if (mem_ready) begin
          if (cls_q == ClsSw) begin
            pc_write = 1'b1;
            state_d  = StFetch;
          end else begin
            state_d = StWriteback;
          end
        end
      end
      StWriteback: begin
        opcode   = alu_q;
        ALUsrc   = alusrc_q;
        RegWrite = 1'b1;
        pc_write = 1'b1;
        MemtoReg = (cls_q == ClsLw);
        state_d  = StFetch;
      end
      StHalt:  state_d = StHalt;
      default: state_d = StIdle;
    endcase
  end

`ifdef CTRL_PERF_CNT_EN
  logic [CNT_W-1:0] cycle_q, retired_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycle_q   <= '0;
      retired_q <= '0;
    end else begin
      if (state_q != StIdle && state_q != StHalt) begin
        cycle_q <= cycle_q + 1'b1;
      end
      if (pc_write) begin
        retired_q <= retired_q + 1'b1;
      end
    end
  end

  assign cycle_cnt   = cycle_q;
  assign retired_cnt = retired_q;
`else
  logic [CNT_W-1:0] unused_cnt;
  assign unused_cnt = '0;
`endif

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Randomized self-checking bench for multicycle_control_unit; expected per-cycle outputs come from
// an instruction-level model (class, ALU code, latency) rather than from the FSM structure.
module tb_multicycle_control_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr;
  logic        zero;
  logic        mem_ready;
  logic        ir_write, pc_write, ALUsrc, RegWrite, MemRW, MemtoReg, PCsrc, illegal;
  logic [3:0]  opcode;
`ifdef CTRL_PERF_CNT_EN
  logic [31:0] cycle_cnt, retired_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always #5 clk = ~clk;

  multicycle_control_unit dut (
    .clk       (clk),
    .reset     (reset),
    .instr     (instr),
    .zero      (zero),
    .mem_ready (mem_ready),
    .ir_write  (ir_write),
    .pc_write  (pc_write),
    .ALUsrc    (ALUsrc),
    .RegWrite  (RegWrite),
    .MemRW     (MemRW),
    .MemtoReg  (MemtoReg),
    .PCsrc     (PCsrc),
    .opcode    (opcode),
    .illegal   (illegal)
`ifdef CTRL_PERF_CNT_EN
    ,
    .cycle_cnt   (cycle_cnt),
    .retired_cnt (retired_cnt)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %h expected %h", tag, cyc, obs, exp);
    end
  endtask

  // Packed output order: ir_write pc_write ALUsrc RegWrite MemRW MemtoReg PCsrc opcode[3:0] illegal
  function automatic logic [11:0] outs();
    return {ir_write, pc_write, ALUsrc, RegWrite, MemRW, MemtoReg, PCsrc, opcode, illegal};
  endfunction

  function automatic logic [11:0] pack(input logic iw, input logic pw, input logic src,
                                       input logic rw, input logic mw, input logic m2r,
                                       input logic pcs, input logic [3:0] op, input logic ill);
    return {iw, pw, src, rw, mw, m2r, pcs, op, ill};
  endfunction

  // 0 R, 1 I-ALU, 2 LW, 3 SW, 4 branch, 5 illegal
  function automatic int kind_of(input logic [31:0] w);
    case (w[6:0])
      7'h33:   return 0;
      7'h13:   return 1;
      7'h03:   return 2;
      7'h23:   return 3;
      7'h63:   return (w[14:12] == 3'b000 || w[14:12] == 3'b001) ? 4 : 5;
      default: return 5;
    endcase
  endfunction

  function automatic logic [3:0] alu_of(input logic [31:0] w);
    logic [3:0] tab [8] = '{4'd1, 4'd6, 4'd5, 4'd5, 4'd4, 4'd7, 4'd3, 4'd0};
    int k = kind_of(w);
    if (k == 2 || k == 3) return 4'd1;
    if (k == 4) return 4'd2;
    if (k == 0 && w[14:12] == 3'b000 && w[30]) return 4'd2;
    return tab[w[14:12]];
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] w = $urandom;
    logic [2:0]  f3 = 3'($urandom_range(0, 7));
    int          r  = $urandom_range(0, 24);
    if (f3 == 3'b011) f3 = 3'b000;
    if (r < 6) begin
      w[6:0] = 7'h33; w[14:12] = f3;
    end else if (r < 11) begin
      w[6:0] = 7'h13; w[14:12] = f3;
    end else if (r < 15) begin
      w[6:0] = 7'h03;
    end else if (r < 19) begin
      w[6:0] = 7'h23;
    end else if (r < 24) begin
      w[6:0] = 7'h63; w[14:12] = 3'($urandom_range(0, 1));
    end else begin
      w[6:0] = 7'h63; w[14:12] = 3'($urandom_range(2, 7));
    end
    return w;
  endfunction

  // Drive one cycle's inputs, check outputs mid-cycle, then advance past the next rising edge.
  task automatic step(input logic mr, input logic z, input logic [11:0] exp, input string tag);
    mem_ready = mr;
    zero      = z;
    @(negedge clk);
    check_eq(tag, {20'd0, outs()}, {20'd0, exp});
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset(input int n);
    reset     = 1'b1;
    mem_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check_eq("reset_outs", {20'd0, outs()}, 32'd0);
      @(posedge clk);
      #1;
    end
    reset = 1'b0;
    step(1'b1, 1'($urandom), 12'd0, "idle");
  endtask

  task automatic run_instr(input logic [31:0] ins, input int fw, input int mw, input logic z,
                           input string name);
    int         k   = kind_of(ins);
    logic [3:0] op  = alu_of(ins);
    logic       src = (k == 1 || k == 2 || k == 3);
    logic       lw  = (k == 2);
    logic       sw  = (k == 3);
    logic       tk  = ins[12] ? ~z : z;
    instr = ins;
    for (int i = 0; i < fw; i++) step(1'b0, 1'($urandom), 12'd0, {name, "_fetchwait"});
    step(1'b1, 1'($urandom), pack(1, 0, 0, 0, 0, 0, 0, 4'd0, 0), {name, "_fetch"});
    instr = $urandom;
    step(1'($urandom), 1'($urandom), 12'd0, {name, "_decode"});
    if (k == 5) begin
      for (int i = 0; i < 4; i++)
        step(1'($urandom), 1'($urandom), pack(0, 0, 0, 0, 0, 0, 0, 4'd0, 1), {name, "_halt"});
      return;
    end
    if (k == 4) begin
      step(1'($urandom), z, pack(0, 1, 0, 0, 0, 0, tk, op, 0), {name, "_branch"});
      return;
    end
    step(1'($urandom), 1'($urandom), pack(0, 0, src, 0, 0, 0, 0, op, 0), {name, "_exec"});
    if (lw || sw) begin
      for (int i = 0; i < mw; i++)
        step(1'b0, 1'($urandom), pack(0, 0, src, 0, sw, 0, 0, op, 0), {name, "_memwait"});
      step(1'b1, 1'($urandom), pack(0, sw, src, 0, sw, 0, 0, op, 0), {name, "_mem"});
    end
    if (!sw)
      step(1'($urandom), 1'($urandom), pack(0, 1, src, 1, 0, lw, 0, op, 0), {name, "_wb"});
  endtask

  task automatic reset_mid_lw();
    instr = 32'h0000_2283;
    step(1'b1, 1'b0, pack(1, 0, 0, 0, 0, 0, 0, 4'd0, 0), "rlw_fetch");
    step(1'b1, 1'b0, 12'd0, "rlw_decode");
    step(1'b1, 1'b0, pack(0, 0, 1, 0, 0, 0, 0, 4'd1, 0), "rlw_exec");
    mem_ready = 1'b0;
    @(negedge clk);
    check_eq("rlw_mem", {20'd0, outs()}, {20'd0, pack(0, 0, 1, 0, 0, 0, 0, 4'd1, 0)});
    #2 reset = 1'b1;
    #1 check_eq("async_reset_outs", {20'd0, outs()}, 32'd0);
    do_reset(2);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset     = 1'b1;
    mem_ready = 1'b0;
    zero      = 1'b0;
    instr     = '0;
    do_reset(3);

    run_instr(32'h0050_0093, 0, 0, 1'b0, "addi");
    run_instr(32'h0020_81B3, 0, 0, 1'b0, "add");
    run_instr(32'h4020_8233, 0, 0, 1'b0, "sub");
    run_instr(32'h0000_2283, 0, 2, 1'b0, "lw");
    run_instr(32'h0050_2223, 1, 1, 1'b0, "sw");
    run_instr(32'h0000_0463, 0, 0, 1'b1, "beq_z1");
    run_instr(32'h0000_0463, 0, 0, 1'b0, "beq_z0");
    run_instr(32'h0000_1463, 0, 0, 1'b1, "bne_z1");
    run_instr(32'h0000_1463, 0, 0, 1'b0, "bne_z0");
    run_instr(32'hFFFF_FFFF, 0, 0, 1'b0, "illegal");
    do_reset(2);
    reset_mid_lw();
    run_instr(32'h0050_0093, 0, 0, 1'b0, "addi_post");

    for (int n = 0; n < 300; n++) begin
      logic [31:0] w = rand_instr();
      run_instr(w, $urandom_range(0, 2), $urandom_range(0, 2), 1'($urandom), "rnd");
      if (kind_of(w) == 5) do_reset(1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
